// File: rtl/pu_pio_arb_pkg.sv
// PU PIO arbiter shared definitions.
// Bus width, default timeout and FSM state encodings.
package pu_pio_arb_pkg;

  localparam int PIO_NBITS = 16;
  localparam int TO_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pu_pio_arb_if.sv
// Requester and PU PIO bus bundle for the arbiter.
// slave: arbiter side; master: requesters plus PIO target.
interface pu_pio_arb_if
  import pu_pio_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = PIO_NBITS
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ-1:0][W-1:0] req_addr;
  logic [NREQ-1:0][W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [W-1:0]           rdata;
  logic                   reg_bs;
  logic                   reg_wr;
  logic                   reg_rd;
  logic [W-1:0]           reg_addr;
  logic [W-1:0]           reg_din;
  logic                   pio_ack;
  logic                   pio_rvalid;
  logic [W-1:0]           pio_rdata;

  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    input  pio_ack, pio_rvalid, pio_rdata,
    output gnt, done, err, rdata,
    output reg_bs, reg_wr, reg_rd,
    output reg_addr, reg_din
  );

  modport master (
    output req, req_wr, req_addr, req_wdata,
    output pio_ack, pio_rvalid, pio_rdata,
    input  gnt, done, err, rdata,
    input  reg_bs, reg_wr, reg_rd,
    input  reg_addr, reg_din
  );

endinterface

// File: rtl/pu_rr_sel.sv
// Round-robin picker: one-hot winner searched
// from the slot after the one-hot last owner.
module pu_rr_sel #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_last,
  output logic [NREQ-1:0] o_gnt
);

  logic w_found;

  // first requester after the last owner wins
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && i_last[j] &&
            i_req[(j+i)%NREQ]) begin
          o_gnt[(j+i)%NREQ] = 1'b1;
          w_found           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pu_pio_arb.sv
// Round-robin arbiter sharing one PU PIO bus
// between NREQ requesters, with timeout.
module pu_pio_arb
  import pu_pio_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input logic        clk,
  input logic        rst,
  pu_pio_arb_if.slave bus
);

  localparam int CW =
    (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CW-1:0] TO_MAX =
    CW'(TO_CYCLES - 1);
  localparam logic [NREQ-1:0] LAST_RST =
    NREQ'(1) << (NREQ - 1);

  state_t                r_state;
  state_t                w_nxt;
  logic [NREQ-1:0]       r_own;
  logic [NREQ-1:0]       r_last;
  logic [NREQ-1:0]       w_win;
  logic                  r_wr;
  logic                  r_fin;
  logic                  r_err;
  logic [CW-1:0]         r_cnt;
  logic [PIO_NBITS-1:0]  r_addr;
  logic [PIO_NBITS-1:0]  r_din;
  logic [PIO_NBITS-1:0]  r_rdata;
  logic                  w_wr;
  logic [PIO_NBITS-1:0]  w_addr;
  logic [PIO_NBITS-1:0]  w_din;
  logic                  w_busy;
  logic                  w_start;
  logic                  w_cmpl;
  logic                  w_to;
  logic                  w_end;

  pu_rr_sel #(.NREQ(NREQ)) u_sel (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_win)
  );

  // pick the winner's access fields
  always_comb begin
    w_wr   = 1'b0;
    w_addr = '0;
    w_din  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win[k]) begin
        w_wr   = bus.req_wr[k];
        w_addr = bus.req_addr[k];
        w_din  = bus.req_wdata[k];
      end
    end
  end

  assign w_busy  = (r_state == S_ISSUE) ||
                   (r_state == S_WAIT);
  assign w_start = (r_state == S_IDLE) &&
                   (|bus.req);
  // only the strobe matching the access type counts
  assign w_cmpl  = w_busy && !r_fin &&
                   (r_wr ? bus.pio_ack
                         : bus.pio_rvalid);
  assign w_to    = w_busy && !r_fin &&
                   (r_cnt == TO_MAX);
  assign w_end   = w_cmpl || w_to;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // next state; ISSUE always passes through WAIT
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|bus.req) w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT:  if (r_fin || w_end) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // latch request, time out, capture the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own   <= '0;
      r_last  <= LAST_RST;
      r_wr    <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_own  <= w_win;
        r_wr   <= w_wr;
        r_addr <= w_addr;
        r_din  <= w_din;
        r_cnt  <= '0;
        r_fin  <= 1'b0;
      end
      if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_cmpl) begin
          r_fin <= 1'b1;
          r_err <= 1'b0;
          if (!r_wr) r_rdata <= bus.pio_rdata;
        end else if (w_to) begin
          r_fin   <= 1'b1;
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (r_state == S_DONE) r_last <= r_own;
    end
  end

  assign bus.gnt      = (r_state == S_IDLE) ?
                        '0 : r_own;
  assign bus.done     = (r_state == S_DONE) ?
                        r_own : '0;
  assign bus.err      = r_err;
  assign bus.rdata    = r_rdata;
  assign bus.reg_bs   = w_busy;
  assign bus.reg_wr   = (r_state == S_ISSUE) &&
                        r_wr;
  assign bus.reg_rd   = (r_state == S_ISSUE) &&
                        !r_wr;
  assign bus.reg_addr = r_addr;
  assign bus.reg_din  = r_din;

endmodule
